// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM driving every datapath enable/select.
// A watchdog halts the core when memory never answers in IF or MEM.
// Optional feature macro: ECALL_HALT_EN (ECALL with halt_cond=1 halts the core from ID).
module multi_cycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] opcode_i,
    input  logic       alu_bcond_i,
    input  logic       mem_ready_i,
    input  logic       halt_cond_i,
    output logic       pc_write_o,
    output logic       pc_source_o,
    output logic       ir_write_o,
    output logic       mdr_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       is_halted_o,
    output logic       mem_error_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IF       = 3'd0,
        S_ID       = 3'd1,
        S_EX       = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_BR_TAKEN = 3'd5,
        S_HALT     = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef ECALL_HALT_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    // Counter must hold TIMEOUT_CYCLES-1; firing happens on the cycle it would reach the limit.
    localparam int              CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_error_q, mem_error_d;

`ifndef ECALL_HALT_EN
    logic unused_halt_cond;
    assign unused_halt_cond = halt_cond_i;
`endif

    // State, watchdog counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IF;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next state plus watchdog; mem_ready on the limit cycle takes priority over the timeout.
    always_comb begin
        logic waiting;
        logic wd_fire;
        state_d     = state_q;
        mem_error_d = mem_error_q;
        waiting     = (state_q == S_IF) || (state_q == S_MEM);
        wd_fire     = waiting && !mem_ready_i && (wait_cnt_q == LIMIT);
        unique case (state_q)
            S_IF: begin
                if (mem_ready_i) state_d = S_ID;
            end
            S_ID: begin
                unique case (opcode_i)
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JALR, OP_JAL: state_d = S_EX;
`ifdef ECALL_HALT_EN
                    OP_SYSTEM: state_d = halt_cond_i ? S_HALT : S_WB;
`endif
                    default:   state_d = S_WB;
                endcase
            end
            S_EX: begin
                unique case (opcode_i)
                    OP_R, OP_I:        state_d = S_WB;
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH:         state_d = alu_bcond_i ? S_BR_TAKEN : S_IF;
                    default:           state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) state_d = (opcode_i == OP_LOAD) ? S_WB : S_IF;
            end
            S_WB, S_BR_TAKEN: state_d = S_IF;
            S_HALT:           state_d = S_HALT;
            default:          state_d = S_IF;
        endcase
        if (wd_fire) begin
            state_d     = S_HALT;
            mem_error_d = 1'b1;
        end
        // Any exit from IF/MEM (including the timeout) leaves the counter cleared for the next entry.
        wait_cnt_d = (waiting && !mem_ready_i && !wd_fire) ? wait_cnt_q + 1'b1 : '0;
    end

    // Moore output decode; everything held low while reset is asserted.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_source_o  = 1'b0;
        ir_write_o   = 1'b0;
        mdr_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        is_halted_o  = 1'b0;
        mem_error_o  = 1'b0;
        state_o      = 3'd0;
        if (!reset_i) begin
            state_o     = state_q;
            mem_error_o = mem_error_q;
            unique case (state_q)
                S_IF: begin
                    mem_read_o = 1'b1;
                    ir_write_o = mem_ready_i;
                end
                S_ID: begin
                    alu_src_b_o = 2'b01;
                end
                S_EX: begin
                    unique case (opcode_i)
                        OP_R: begin
                            alu_src_a_o = 1'b1;
                            alu_op_o    = 2'b10;
                        end
                        OP_I: begin
                            alu_src_a_o = 1'b1;
                            alu_src_b_o = 2'b10;
                            alu_op_o    = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a_o = 1'b1;
                            alu_src_b_o = 2'b10;
                        end
                        OP_BRANCH: begin
                            alu_src_a_o = 1'b1;
                            alu_op_o    = 2'b01;
                            // Not taken: PC <= PC+4 already sitting in ALUOut.
                            if (!alu_bcond_i) begin
                                pc_write_o  = 1'b1;
                                pc_source_o = 1'b1;
                            end
                        end
                        OP_JAL, OP_JALR: begin
                            alu_src_a_o = (opcode_i == OP_JALR);
                            alu_src_b_o = 2'b10;
                            pc_write_o  = 1'b1;
                            reg_write_o = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d_o = 1'b1;
                    if (opcode_i == OP_LOAD) begin
                        mem_read_o  = 1'b1;
                        mdr_write_o = mem_ready_i;
                    end else begin
                        mem_write_o = 1'b1;
                        if (mem_ready_i) begin
                            pc_write_o  = 1'b1;
                            alu_src_b_o = 2'b01;
                        end
                    end
                end
                S_WB: begin
                    pc_write_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    if (opcode_i == OP_R || opcode_i == OP_I) reg_write_o = 1'b1;
                    if (opcode_i == OP_LOAD) begin
                        reg_write_o  = 1'b1;
                        mem_to_reg_o = 1'b1;
                    end
                end
                S_BR_TAKEN: begin
                    pc_write_o  = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_HALT: begin
                    is_halted_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench: stimulus pushes the hand-derived expected control word for each
// cycle; a monitor on the falling edge pops and compares it against the DUT outputs.
module tb_multi_cycle_control_unit;

    typedef struct packed {
        logic       pc_write, pc_source, ir_write, mdr_write, i_or_d, mem_read, mem_write;
        logic       reg_write, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       is_halted, mem_error;
        logic [2:0] state;
    } ctl_t;

    typedef struct {
        ctl_t  c;
        string tag;
    } exp_t;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111;
    localparam logic [6:0] ECALL = 7'b1110011, LUI = 7'b0110111;

    localparam ctl_t C_RST   = '{default: '0};
    localparam ctl_t C_IF_W  = '{default: '0, mem_read: 1'b1, state: 3'd0};
    localparam ctl_t C_IF_R  = '{default: '0, mem_read: 1'b1, ir_write: 1'b1, state: 3'd0};
    localparam ctl_t C_ID    = '{default: '0, alu_src_b: 2'b01, state: 3'd1};
    localparam ctl_t C_EX_R  = '{default: '0, alu_src_a: 1'b1, alu_op: 2'b10, state: 3'd2};
    localparam ctl_t C_EX_I  = '{default: '0, alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 2'b10, state: 3'd2};
    localparam ctl_t C_EX_LS = '{default: '0, alu_src_a: 1'b1, alu_src_b: 2'b10, state: 3'd2};
    localparam ctl_t C_EX_BT = '{default: '0, alu_src_a: 1'b1, alu_op: 2'b01, state: 3'd2};
    localparam ctl_t C_EX_BN = '{default: '0, alu_src_a: 1'b1, alu_op: 2'b01, pc_write: 1'b1,
                                 pc_source: 1'b1, state: 3'd2};
    localparam ctl_t C_EX_J  = '{default: '0, pc_write: 1'b1, reg_write: 1'b1, alu_src_b: 2'b10, state: 3'd2};
    localparam ctl_t C_EX_JR = '{default: '0, pc_write: 1'b1, reg_write: 1'b1, alu_src_a: 1'b1,
                                 alu_src_b: 2'b10, state: 3'd2};
    localparam ctl_t C_BRT   = '{default: '0, pc_write: 1'b1, alu_src_b: 2'b10, state: 3'd5};
    localparam ctl_t C_MLD_W = '{default: '0, mem_read: 1'b1, i_or_d: 1'b1, state: 3'd3};
    localparam ctl_t C_MLD_R = '{default: '0, mem_read: 1'b1, i_or_d: 1'b1, mdr_write: 1'b1, state: 3'd3};
    localparam ctl_t C_MST_W = '{default: '0, mem_write: 1'b1, i_or_d: 1'b1, state: 3'd3};
    localparam ctl_t C_MST_R = '{default: '0, mem_write: 1'b1, i_or_d: 1'b1, pc_write: 1'b1,
                                 alu_src_b: 2'b01, state: 3'd3};
    localparam ctl_t C_WB_A  = '{default: '0, pc_write: 1'b1, alu_src_b: 2'b01, reg_write: 1'b1, state: 3'd4};
    localparam ctl_t C_WB_L  = '{default: '0, pc_write: 1'b1, alu_src_b: 2'b01, reg_write: 1'b1,
                                 mem_to_reg: 1'b1, state: 3'd4};
    localparam ctl_t C_WB_N  = '{default: '0, pc_write: 1'b1, alu_src_b: 2'b01, state: 3'd4};
    localparam ctl_t C_HLT_E = '{default: '0, is_halted: 1'b1, mem_error: 1'b1, state: 3'd7};
`ifdef ECALL_HALT_EN
    localparam ctl_t C_HLT   = '{default: '0, is_halted: 1'b1, state: 3'd7};
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       alu_bcond = 1'b0, mem_ready = 1'b0, halt_cond = 1'b0;
    logic       pc_write, pc_source, ir_write, mdr_write, i_or_d, mem_read, mem_write;
    logic       reg_write, mem_to_reg, alu_src_a, is_halted, mem_error;
    logic [1:0] alu_src_b, alu_op;
    logic [2:0] state;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    ctl_t got;

    always #5 clk = ~clk;

    multi_cycle_control_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .alu_bcond_i(alu_bcond),
        .mem_ready_i(mem_ready), .halt_cond_i(halt_cond),
        .pc_write_o(pc_write), .pc_source_o(pc_source), .ir_write_o(ir_write),
        .mdr_write_o(mdr_write), .i_or_d_o(i_or_d), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .is_halted_o(is_halted), .mem_error_o(mem_error), .state_o(state)
    );

    assign got = {pc_write, pc_source, ir_write, mdr_write, i_or_d, mem_read, mem_write,
                  reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted, mem_error, state};

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e.c) begin
                failures++;
                $display("FAIL %s: got=%05h (state %0d) expected=%05h (state %0d)",
                         e.tag, got, got.state, e.c, e.c.state);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs they should produce.
    task automatic cyc(input logic [6:0] op, input logic rdy, input logic bc, input logic hc,
                       input logic rst, input ctl_t e, input string tag);
        exp_t x;
        opcode = op; mem_ready = rdy; alu_bcond = bc; halt_cond = hc; reset = rst;
        x.c = e; x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        // reset state
        cyc(R, 1, 0, 0, 1, C_RST, "reset0");
        cyc(R, 1, 0, 0, 1, C_RST, "reset1");
        // ADD: IF,ID,EX,WB
        cyc(R, 1, 0, 0, 0, C_IF_R, "add_if");
        cyc(R, 0, 0, 0, 0, C_ID,   "add_id");
        cyc(R, 0, 0, 0, 0, C_EX_R, "add_ex");
        cyc(R, 0, 0, 0, 0, C_WB_A, "add_wb");
        // ADDI with mem_ready high outside IF/MEM (ignored)
        cyc(I, 1, 0, 0, 0, C_IF_R, "addi_if");
        cyc(I, 1, 0, 0, 0, C_ID,   "addi_id");
        cyc(I, 1, 0, 0, 0, C_EX_I, "addi_ex");
        cyc(I, 1, 0, 0, 0, C_WB_A, "addi_wb");
        // LW: one IF wait, MEM waits 3 cycles
        cyc(LD, 0, 0, 0, 0, C_IF_W,  "lw_if_wait");
        cyc(LD, 1, 0, 0, 0, C_IF_R,  "lw_if");
        cyc(LD, 0, 0, 0, 0, C_ID,    "lw_id");
        cyc(LD, 0, 0, 0, 0, C_EX_LS, "lw_ex");
        for (int k = 0; k < 3; k++) cyc(LD, 0, 0, 0, 0, C_MLD_W, "lw_mem_wait");
        cyc(LD, 1, 0, 0, 0, C_MLD_R, "lw_mem_rdy");
        cyc(LD, 0, 0, 0, 0, C_WB_L,  "lw_wb");
        // SW
        cyc(ST, 1, 0, 0, 0, C_IF_R,  "sw_if");
        cyc(ST, 0, 0, 0, 0, C_ID,    "sw_id");
        cyc(ST, 0, 0, 0, 0, C_EX_LS, "sw_ex");
        cyc(ST, 0, 0, 0, 0, C_MST_W, "sw_mem_wait");
        cyc(ST, 1, 0, 0, 0, C_MST_R, "sw_mem_rdy");
        // BEQ taken / not taken
        cyc(BR, 1, 0, 0, 0, C_IF_R,  "beq_t_if");
        cyc(BR, 0, 0, 0, 0, C_ID,    "beq_t_id");
        cyc(BR, 0, 1, 0, 0, C_EX_BT, "beq_t_ex");
        cyc(BR, 0, 0, 0, 0, C_BRT,   "beq_t_brt");
        cyc(BR, 1, 0, 0, 0, C_IF_R,  "beq_n_if");
        cyc(BR, 0, 0, 0, 0, C_ID,    "beq_n_id");
        cyc(BR, 0, 0, 0, 0, C_EX_BN, "beq_n_ex");
        // JAL, JALR
        cyc(JAL, 1, 0, 0, 0, C_IF_R,   "jal_if");
        cyc(JAL, 0, 0, 0, 0, C_ID,     "jal_id");
        cyc(JAL, 0, 0, 0, 0, C_EX_J,   "jal_ex");
        cyc(JALR, 1, 0, 0, 0, C_IF_R,  "jalr_if");
        cyc(JALR, 0, 0, 0, 0, C_ID,    "jalr_id");
        cyc(JALR, 0, 0, 0, 0, C_EX_JR, "jalr_ex");
        // LUI falls to WB without register write
        cyc(LUI, 1, 0, 0, 0, C_IF_R, "lui_if");
        cyc(LUI, 0, 0, 0, 0, C_ID,   "lui_id");
        cyc(LUI, 0, 0, 0, 0, C_WB_N, "lui_wb");
        // ECALL with halt_cond=1
        cyc(ECALL, 1, 0, 1, 0, C_IF_R, "ecall_if");
        cyc(ECALL, 0, 0, 1, 0, C_ID,   "ecall_id");
`ifdef ECALL_HALT_EN
        cyc(ECALL, 1, 0, 1, 0, C_HLT, "ecall_halt0");
        cyc(ECALL, 1, 0, 1, 0, C_HLT, "ecall_halt1");
        cyc(ECALL, 0, 0, 0, 1, C_RST, "ecall_reset");
`else
        cyc(ECALL, 0, 0, 1, 0, C_WB_N, "ecall_wb");
`endif
        // Watchdog in IF: 4 waiting cycles then HALT with mem_error; reset clears
        for (int k = 0; k < 4; k++) cyc(R, 0, 0, 0, 0, C_IF_W, "wd_if_wait");
        cyc(R, 1, 0, 0, 0, C_HLT_E, "wd_halt0");
        cyc(R, 1, 0, 0, 0, C_HLT_E, "wd_halt1");
        cyc(R, 1, 0, 0, 1, C_RST,   "wd_reset");
        cyc(R, 1, 0, 0, 0, C_IF_R,  "wd_after_if");
        cyc(R, 0, 0, 0, 0, C_ID,    "wd_after_id");
        cyc(R, 0, 0, 0, 0, C_EX_R,  "wd_after_ex");
        cyc(R, 0, 0, 0, 0, C_WB_A,  "wd_after_wb");
        // mem_ready on the limit cycle wins
        for (int k = 0; k < 3; k++) cyc(R, 0, 0, 0, 0, C_IF_W, "lim_if_wait");
        cyc(R, 1, 0, 0, 0, C_IF_R, "lim_if_rdy");
        cyc(R, 0, 0, 0, 0, C_ID,   "lim_id");
        cyc(R, 0, 0, 0, 0, C_EX_R, "lim_ex");
        cyc(R, 0, 0, 0, 0, C_WB_A, "lim_wb");
        // Reset mid-wait restarts the watchdog count
        cyc(R, 0, 0, 0, 0, C_IF_W, "rmw_wait0");
        cyc(R, 0, 0, 0, 0, C_IF_W, "rmw_wait1");
        cyc(R, 0, 0, 0, 1, C_RST,  "rmw_reset");
        for (int k = 0; k < 3; k++) cyc(R, 0, 0, 0, 0, C_IF_W, "rmw_wait");
        cyc(R, 1, 0, 0, 0, C_IF_R, "rmw_if_rdy");
        cyc(R, 0, 0, 0, 0, C_ID,   "rmw_id");
        cyc(R, 0, 0, 0, 0, C_EX_R, "rmw_ex");
        cyc(R, 0, 0, 0, 0, C_WB_A, "rmw_wb");
        // Watchdog in MEM during a load
        cyc(LD, 1, 0, 0, 0, C_IF_R,  "wdm_if");
        cyc(LD, 0, 0, 0, 0, C_ID,    "wdm_id");
        cyc(LD, 0, 0, 0, 0, C_EX_LS, "wdm_ex");
        for (int k = 0; k < 4; k++) cyc(LD, 0, 0, 0, 0, C_MLD_W, "wdm_mem_wait");
        cyc(LD, 0, 0, 0, 0, C_HLT_E, "wdm_halt");
        cyc(LD, 0, 0, 0, 1, C_RST,   "wdm_reset");
        cyc(LD, 0, 0, 0, 0, C_IF_W,  "wdm_after");
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
